// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with a 16-byte register file, auto-incrementing pointer and fabric write port
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h68,
  parameter int         NREG    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       loc_we,
  input  logic [3:0] loc_addr,
  input  logic [7:0] loc_data,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_t;

  state_t      state, state_d;
  logic [2:0]  scl_q, sda_q;
  logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [2:0]  cnt, cnt_d;
  logic [7:0]  sh, sh_d;
  logic [3:0]  ptr, ptr_d, ptr_inc;
  logic        rw, rw_d;
  logic        sda_oe_d, busy_d, wr_valid_d;
  logic [3:0]  wr_addr_d;
  logic [7:0]  wr_data_d;
  logic        bus_we;
  logic [7:0]  rx_byte;
  logic [7:0]  regs [0:NREG-1];

  // Stages 0/1 synchronize; stage 2 is the delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = ~sda_q[1] & sda_q[2] & scl_q[1];
  assign stop_det  = sda_q[1] & ~sda_q[2] & scl_q[1];
  assign rx_byte   = {sh[6:0], sda_s};
  assign ptr_inc   = ptr + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      cnt      <= 3'd0;
      sh       <= 8'h00;
      ptr      <= 4'd0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 8'h00;
    end else begin
      state    <= state_d;
      sda_oe   <= sda_oe_d;
      cnt      <= cnt_d;
      sh       <= sh_d;
      ptr      <= ptr_d;
      rw       <= rw_d;
      busy     <= busy_d;
      wr_valid <= wr_valid_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
    end
  end

  // ACK states use sda_oe as the phase flag: first fall drives ACK, second fall ends it
  always_comb begin
    state_d    = state;
    sda_oe_d   = sda_oe;
    cnt_d      = cnt;
    sh_d       = sh;
    ptr_d      = ptr;
    rw_d       = rw;
    busy_d     = busy;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    bus_we     = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
    end else begin
      case (state)
        IDLE, WAIT: begin
        end
        ADDR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (rx_byte[7:1] == ADDRESS) begin
                state_d = ADDR_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else if (rw) begin
              sda_oe_d = ~regs[ptr][7];
              sh_d     = {regs[ptr][6:0], 1'b0};
              cnt_d    = 3'd0;
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr_d   = rx_byte[3:0];
              state_d = PTR_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = WDATA;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            sh_d  = rx_byte;
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              bus_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr;
              wr_data_d  = rx_byte;
              ptr_d      = ptr_inc;
              state_d    = WDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~sh[7];
            sh_d     = {sh[6:0], 1'b0};
          end else if (scl_rise) begin
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) state_d = RACK;
          end
        end
        RACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_s) begin
              sh_d    = regs[ptr_inc];
              cnt_d   = 3'd0;
              state_d = RDATA;
            end else begin
              state_d = WAIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus write is issued after the local write so it wins on an address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      if (loc_we) regs[loc_addr] <= loc_data;
      if (bus_we) regs[ptr] <= rx_byte;
    end
  end

endmodule
